// File: rtl/snake_pkg.sv
// Shared constants and colour encoding for the snake pixel renderer.
// The renderer's optional grid-line overlay is enabled by defining SNAKE_GRID_LINES_EN.
package snake_pkg;

  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 30;
  localparam int CELL_X_W   = 6;
  localparam int CELL_Y_W   = 5;

  typedef enum logic [2:0] {
    COL_BLACK,
    COL_HEAD,
    COL_BODY,
    COL_FOOD,
    COL_BORDER,
    COL_GRID
  } colour_e;

  // Channel intensities; the renderer scales these to its own channel width.
  typedef enum logic [1:0] {
    LVL_ZERO,
    LVL_DIM,
    LVL_HALF,
    LVL_FULL
  } level_e;

  typedef struct packed {
    level_e r;
    level_e g;
    level_e b;
  } rgb_lvl_t;

  function automatic rgb_lvl_t colour_levels(input colour_e c);
    rgb_lvl_t l;
    l = '{r: LVL_ZERO, g: LVL_ZERO, b: LVL_ZERO};
    case (c)
      COL_HEAD:   l = '{r: LVL_FULL, g: LVL_FULL, b: LVL_ZERO};
      COL_BODY:   l = '{r: LVL_ZERO, g: LVL_FULL, b: LVL_ZERO};
      COL_FOOD:   l = '{r: LVL_FULL, g: LVL_ZERO, b: LVL_ZERO};
      COL_BORDER: l = '{r: LVL_HALF, g: LVL_HALF, b: LVL_HALF};
      COL_GRID:   l = '{r: LVL_DIM,  g: LVL_DIM,  b: LVL_DIM};
      default:    l = '{r: LVL_ZERO, g: LVL_ZERO, b: LVL_ZERO};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/snake_seg_compare.sv
// Parallel compare of one grid cell against every live entry of the segment table.
// Entry 0 is the head; entries beyond len are ignored.
module snake_seg_compare
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 16,
  localparam int LEN_W  = $clog2(MAX_LEN) + 1
) (
  input  logic [CELL_X_W-1:0] cx_i,
  input  logic [CELL_Y_W-1:0] cy_i,
  input  logic [CELL_X_W-1:0] seg_x_i [MAX_LEN],
  input  logic [CELL_Y_W-1:0] seg_y_i [MAX_LEN],
  input  logic [LEN_W-1:0]    len_i,
  output logic                head_hit_o,
  output logic                body_hit_o
);

  always_comb begin
    head_hit_o = 1'b0;
    body_hit_o = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < len_i) && (seg_x_i[i] == cx_i) && (seg_y_i[i] == cy_i)) begin
        if (i == 0) head_hit_o = 1'b1;
        else        body_hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_pixel_renderer.sv
// Two-stage snake game pixel renderer with a tear-free shadow/active segment table.
// Define SNAKE_GRID_LINES_EN to draw dim cell grid lines on the background.
module snake_pixel_renderer
  import snake_pkg::*;
#(
  parameter int CELL_SHIFT = 4,
  parameter int MAX_LEN    = 16,
  parameter int GRID_W     = GRID_W_DEF,
  parameter int GRID_H     = GRID_H_DEF,
  parameter int COLOR_W    = 4,
  localparam int IDX_W     = $clog2(MAX_LEN),
  localparam int LEN_W     = IDX_W + 1
) (
  input  logic                VGA_clk,
  input  logic                reset_n,
  input  logic [9:0]          x_pos,
  input  logic [9:0]          y_pos,
  input  logic                display_enable,
  input  logic                hsync,
  input  logic                vsync,
  input  logic                seg_wr_en,
  input  logic [IDX_W-1:0]    seg_wr_idx,
  input  logic [CELL_X_W-1:0] seg_wr_x,
  input  logic [CELL_Y_W-1:0] seg_wr_y,
  input  logic [LEN_W-1:0]    snake_len,
  input  logic [CELL_X_W-1:0] food_x,
  input  logic [CELL_Y_W-1:0] food_y,
  input  logic                commit,
  output logic                swap_done,
  output logic [COLOR_W-1:0]  red,
  output logic [COLOR_W-1:0]  green,
  output logic [COLOR_W-1:0]  blue,
  output logic                hsync_out,
  output logic                vsync_out
);

  localparam int CX_W = 10 - CELL_SHIFT;

  logic [CELL_X_W-1:0] shadow_x_q [MAX_LEN];
  logic [CELL_Y_W-1:0] shadow_y_q [MAX_LEN];
  logic [CELL_X_W-1:0] active_x_q [MAX_LEN];
  logic [CELL_Y_W-1:0] active_y_q [MAX_LEN];
  logic [LEN_W-1:0]    shadow_len_q, active_len_q, len_clamped;
  logic [CELL_X_W-1:0] shadow_fx_q, active_fx_q;
  logic [CELL_Y_W-1:0] shadow_fy_q, active_fy_q;
  logic                pending_q, pending_d, swap_done_q, boundary, swap;

  logic [CX_W-1:0]     cx_s1_q, cy_s1_q;
  logic                de_s1_q, hs_s1_q, vs_s1_q, hs_s2_q, vs_s2_q;
  logic [COLOR_W-1:0]  red_q, green_q, blue_q, red_d, green_d, blue_d;
  logic                head_hit, body_hit, food_hit, border, off_grid;
  colour_e             col;
  rgb_lvl_t            lvl;
`ifdef SNAKE_GRID_LINES_EN
  logic                fine_edge_s1_q;
`endif

  // The frame boundary is the falling edge of vsync as seen against the S1 copy.
  assign boundary    = vs_s1_q && !vsync;
  assign swap        = boundary && pending_q;
  assign pending_d   = commit ? 1'b1 : (swap ? 1'b0 : pending_q);
  assign len_clamped = (snake_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : snake_len;

  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        shadow_x_q[i] <= '0;
        shadow_y_q[i] <= '0;
        active_x_q[i] <= '0;
        active_y_q[i] <= '0;
      end
      shadow_len_q <= '0;
      active_len_q <= '0;
      shadow_fx_q  <= '0;
      shadow_fy_q  <= '0;
      active_fx_q  <= '0;
      active_fy_q  <= '0;
      pending_q    <= 1'b0;
      swap_done_q  <= 1'b0;
    end else begin
      if (seg_wr_en) begin
        shadow_x_q[seg_wr_idx] <= seg_wr_x;
        shadow_y_q[seg_wr_idx] <= seg_wr_y;
      end
      if (commit) begin
        shadow_len_q <= len_clamped;
        shadow_fx_q  <= food_x;
        shadow_fy_q  <= food_y;
      end
      if (swap) begin
        active_x_q   <= shadow_x_q;
        active_y_q   <= shadow_y_q;
        active_len_q <= shadow_len_q;
        active_fx_q  <= shadow_fx_q;
        active_fy_q  <= shadow_fy_q;
      end
      pending_q   <= pending_d;
      swap_done_q <= swap;
    end
  end

  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      cx_s1_q <= '0;
      cy_s1_q <= '0;
      de_s1_q <= 1'b0;
      hs_s1_q <= 1'b1;
      vs_s1_q <= 1'b1;
`ifdef SNAKE_GRID_LINES_EN
      fine_edge_s1_q <= 1'b0;
`endif
    end else begin
      cx_s1_q <= CX_W'(x_pos >> CELL_SHIFT);
      cy_s1_q <= CX_W'(y_pos >> CELL_SHIFT);
      de_s1_q <= display_enable;
      hs_s1_q <= hsync;
      vs_s1_q <= vsync;
`ifdef SNAKE_GRID_LINES_EN
      fine_edge_s1_q <= (x_pos[CELL_SHIFT-1:0] == '0) || (y_pos[CELL_SHIFT-1:0] == '0);
`endif
    end
  end

  snake_seg_compare #(.MAX_LEN(MAX_LEN)) u_cmp (
    .cx_i       (CELL_X_W'(cx_s1_q)),
    .cy_i       (CELL_Y_W'(cy_s1_q)),
    .seg_x_i    (active_x_q),
    .seg_y_i    (active_y_q),
    .len_i      (active_len_q),
    .head_hit_o (head_hit),
    .body_hit_o (body_hit)
  );

  // Off-grid is checked first, so truncated row bits can never produce a false hit.
  assign off_grid = (cx_s1_q >= CX_W'(GRID_W)) || (cy_s1_q >= CX_W'(GRID_H));
  assign food_hit = (CELL_X_W'(cx_s1_q) == active_fx_q) && (CELL_Y_W'(cy_s1_q) == active_fy_q);
  assign border   = (cx_s1_q == '0) || (cx_s1_q == CX_W'(GRID_W - 1)) ||
                    (cy_s1_q == '0) || (cy_s1_q == CX_W'(GRID_H - 1));

  function automatic logic [COLOR_W-1:0] level_val(input level_e l);
    logic [COLOR_W-1:0] v;
    case (l)
      LVL_FULL: v = '1;
      LVL_HALF: v = COLOR_W'(1) << (COLOR_W - 1);
      LVL_DIM:  v = COLOR_W'(2);
      default:  v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    col = COL_BLACK;
    if (!de_s1_q || off_grid) col = COL_BLACK;
    else if (head_hit)        col = COL_HEAD;
    else if (body_hit)        col = COL_BODY;
    else if (food_hit)        col = COL_FOOD;
    else if (border)          col = COL_BORDER;
`ifdef SNAKE_GRID_LINES_EN
    else if (fine_edge_s1_q)  col = COL_GRID;
`endif
    lvl     = colour_levels(col);
    red_d   = level_val(lvl.r);
    green_d = level_val(lvl.g);
    blue_d  = level_val(lvl.b);
  end

  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hs_s2_q <= 1'b1;
      vs_s2_q <= 1'b1;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hs_s2_q <= hs_s1_q;
      vs_s2_q <= vs_s1_q;
    end
  end

  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;
  assign hsync_out = hs_s2_q;
  assign vsync_out = vs_s2_q;
  assign swap_done = swap_done_q;

endmodule

// File: tb/tb_snake_pixel_renderer.sv
// Directed bench for snake_pixel_renderer: pixel expectations flow through a queue to a monitor.
// Build with SNAKE_GRID_LINES_EN to expect the grid-line colour at x_pos=32.
module tb_snake_pixel_renderer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] x_pos, y_pos;
  logic       display_enable, hsync, vsync;
  logic       seg_wr_en;
  logic [3:0] seg_wr_idx;
  logic [5:0] seg_wr_x;
  logic [4:0] seg_wr_y;
  logic [4:0] snake_len;
  logic [5:0] food_x;
  logic [4:0] food_y;
  logic       commit;
  logic       swap_done;
  logic [3:0] red, green, blue;
  logic       hsync_out, vsync_out;

`ifdef SNAKE_GRID_LINES_EN
  localparam logic [11:0] GRID_RGB = 12'h222;
`else
  localparam logic [11:0] GRID_RGB = 12'h000;
`endif

  // ---------------- clock / reset
  always #5 clk = ~clk;

  snake_pixel_renderer dut (
    .VGA_clk        (clk),
    .reset_n        (reset_n),
    .x_pos          (x_pos),
    .y_pos          (y_pos),
    .display_enable (display_enable),
    .hsync          (hsync),
    .vsync          (vsync),
    .seg_wr_en      (seg_wr_en),
    .seg_wr_idx     (seg_wr_idx),
    .seg_wr_x       (seg_wr_x),
    .seg_wr_y       (seg_wr_y),
    .snake_len      (snake_len),
    .food_x         (food_x),
    .food_y         (food_y),
    .commit         (commit),
    .swap_done      (swap_done),
    .red            (red),
    .green          (green),
    .blue           (blue),
    .hsync_out      (hsync_out),
    .vsync_out      (vsync_out)
  );

  // ---------------- scoreboard
  int          n_vec = 0;
  int          n_err = 0;
  logic [13:0] exp_q[$];
  logic        tag0 = 1'b0, tag1 = 1'b0, tag2 = 1'b0;
  logic        sd0 = 1'b0, sd1 = 1'b0;

  always @(posedge clk) begin
    tag1 <= tag0;
    tag2 <= tag1;
    sd1  <= sd0;
  end

  always @(negedge clk) begin
    logic [13:0] e, got;
    if (tag1) begin
      n_vec++;
      if (swap_done !== sd1) begin
        n_err++;
        $display("FAIL swap_done t=%0t: got %b want %b", $time, swap_done, sd1);
      end
    end
    if (tag2) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pixel_queue t=%0t: got empty queue want an entry", $time);
      end else begin
        e   = exp_q.pop_front();
        got = {red, green, blue, hsync_out, vsync_out};
        if (got !== e) begin
          n_err++;
          $display("FAIL pixel t=%0t: got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                   $time, got[13:2], got[1], got[0], e[13:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // ---------------- driver tasks (entered and left at posedge+1)
  task automatic px(input logic [9:0] x, input logic [9:0] y, input logic de,
                    input logic hs, input logic vs, input logic [11:0] rgb, input logic sd);
    x_pos = x; y_pos = y; display_enable = de; hsync = hs; vsync = vs;
    exp_q.push_back({rgb, hs, vs});
    tag0 = 1'b1;
    sd0  = sd;
    @(posedge clk); #1;
    tag0 = 1'b0; sd0 = 1'b0; commit = 1'b0; seg_wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      x_pos = 10'd100; y_pos = 10'd100; display_enable = 1'b1; hsync = 1'b1; vsync = 1'b1;
      @(posedge clk); #1;
      commit = 1'b0; seg_wr_en = 1'b0;
    end
  endtask

  task automatic wr_seg(input logic [3:0] idx, input logic [5:0] cx, input logic [4:0] cy);
    seg_wr_en = 1'b1; seg_wr_idx = idx; seg_wr_x = cx; seg_wr_y = cy;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus want finish before 200000");
    $fatal(1);
  end

  // ---------------- stimulus
  initial begin
    logic [1:0] pat [8];
    pat = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11};
    reset_n = 1'b0;
    x_pos = 10'd100; y_pos = 10'd100; display_enable = 1'b0; hsync = 1'b1; vsync = 1'b1;
    seg_wr_en = 1'b0; seg_wr_idx = '0; seg_wr_x = '0; seg_wr_y = '0;
    snake_len = '0; food_x = '0; food_y = '0; commit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {1'b0, red, green, blue, hsync_out, vsync_out, swap_done}, {1'b0, 12'h000, 3'b110});
    reset_n = 1'b1;

    // 1: empty tables -> border / black only
    px(10'd100, 10'd0,   1, 1, 1, 12'h888, 0);
    px(10'd100, 10'd100, 1, 1, 1, 12'h000, 0);
    px(10'd4,   10'd100, 1, 1, 1, 12'h888, 0);
    px(10'd636, 10'd100, 1, 1, 1, 12'h888, 0);
    px(10'd100, 10'd468, 1, 1, 1, 12'h888, 0);
    px(10'd700, 10'd100, 1, 1, 1, 12'h000, 0);
    px(10'd100, 10'd500, 1, 1, 1, 12'h000, 0);
    px(10'd84,  10'd84,  1, 1, 1, 12'h000, 0);

    // 2: commit mid-frame, visible only after vsync falls
    wr_seg(4'd0, 6'd5, 5'd5);
    wr_seg(4'd1, 6'd4, 5'd5);
    snake_len = 5'd2; food_x = 6'd10; food_y = 5'd7; commit = 1'b1;
    idle(1);
    px(10'd84,  10'd84,  1, 1, 1, 12'h000, 0);
    px(10'd164, 10'd116, 1, 1, 1, 12'h000, 0);
    px(10'd100, 10'd100, 1, 1, 0, 12'h000, 1);
    px(10'd100, 10'd100, 1, 1, 0, 12'h000, 0);
    px(10'd84,  10'd84,  1, 1, 1, 12'hFF0, 0);
    px(10'd68,  10'd84,  1, 1, 1, 12'h0F0, 0);
    px(10'd164, 10'd116, 1, 1, 1, 12'hF00, 0);
    px(10'd100, 10'd84,  1, 1, 1, 12'h000, 0);

    // 3: commit on the boundary cycle waits for the following boundary
    food_x = 6'd20; food_y = 5'd10; commit = 1'b1;
    px(10'd100, 10'd100, 1, 1, 0, 12'h000, 0);
    px(10'd100, 10'd100, 1, 1, 0, 12'h000, 0);
    px(10'd164, 10'd116, 1, 1, 1, 12'hF00, 0);
    px(10'd324, 10'd164, 1, 1, 1, 12'h000, 0);
    px(10'd100, 10'd100, 1, 1, 0, 12'h000, 1);
    px(10'd324, 10'd164, 1, 1, 0, 12'hF00, 0);
    px(10'd164, 10'd116, 1, 1, 1, 12'h000, 0);

    // 4a: len=0 draws no snake
    snake_len = 5'd0; commit = 1'b1;
    idle(1);
    px(10'd100, 10'd100, 1, 1, 0, 12'h000, 1);
    px(10'd84,  10'd84,  1, 1, 1, 12'h000, 0);
    px(10'd68,  10'd84,  1, 1, 1, 12'h000, 0);
    px(10'd324, 10'd164, 1, 1, 1, 12'hF00, 0);

    // 4b: len=31 clamps to 16; a write on the swap cycle stays in the shadow
    for (int i = 0; i < 16; i++) wr_seg(4'(i), 6'(i + 1), 5'd20);
    snake_len = 5'd31; commit = 1'b1;
    idle(1);
    seg_wr_en = 1'b1; seg_wr_idx = 4'd0; seg_wr_x = 6'd30; seg_wr_y = 5'd25;
    px(10'd100, 10'd100, 1, 1, 0, 12'h000, 1);
    px(10'd20,  10'd324, 1, 1, 1, 12'hFF0, 0);
    px(10'd260, 10'd324, 1, 1, 1, 12'h0F0, 0);
    px(10'd276, 10'd324, 1, 1, 1, 12'h000, 0);
    px(10'd484, 10'd404, 1, 1, 1, 12'h000, 0);

    // 4c: repeated commits while pending -> last wins, one swap
    food_x = 6'd1; food_y = 5'd1; commit = 1'b1;
    idle(1);
    food_x = 6'd2; food_y = 5'd2; commit = 1'b1;
    idle(1);
    px(10'd100, 10'd100, 1, 1, 0, 12'h000, 1);
    px(10'd100, 10'd100, 1, 1, 0, 12'h000, 0);
    px(10'd36,  10'd36,  1, 1, 1, 12'hF00, 0);
    px(10'd20,  10'd20,  1, 1, 1, 12'h000, 0);
    px(10'd484, 10'd404, 1, 1, 1, 12'hFF0, 0);
    px(10'd20,  10'd324, 1, 1, 1, 12'h000, 0);

    // 5: de=0 on the head cell, then a sync toggle pattern
    px(10'd484, 10'd404, 0, 1, 1, 12'h000, 0);
    for (int i = 0; i < 8; i++) px(10'd100, 10'd100, 1, pat[i][1], pat[i][0], 12'h000, 0);

    // 6: reset mid-frame with a pending commit
    commit = 1'b1;
    idle(1);
    idle(3);
    reset_n = 1'b0;
    #1;
    check("midframe_reset", {1'b0, red, green, blue, hsync_out, vsync_out, swap_done}, {1'b0, 12'h000, 3'b110});
    idle(3);
    check("reset_held", {1'b0, red, green, blue, hsync_out, vsync_out, swap_done}, {1'b0, 12'h000, 3'b110});
    reset_n = 1'b1;
    px(10'd100, 10'd100, 1, 1, 1, 12'h000, 0);
    px(10'd100, 10'd100, 1, 1, 0, 12'h000, 0);
    px(10'd100, 10'd100, 1, 1, 0, 12'h000, 0);
    px(10'd484, 10'd404, 1, 1, 1, 12'h000, 0);
    px(10'd32,  10'd100, 1, 1, 1, GRID_RGB, 0);
    idle(4);

    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
